// File: rtl/knap_pkg.sv
// Shared types and helpers for the sequential knapsack candidate evaluator.
// Coefficient record, FSM encoding and a width-bounded saturating adder.
package knap_pkg;

  localparam int KNAP_COEF_W = 8;

  typedef struct packed {
    logic [KNAP_COEF_W-1:0] value;
    logic [KNAP_COEF_W-1:0] weight;
    logic [KNAP_COEF_W-1:0] volume;
  } coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Clamps a + b to 2^w - 1 and reports whether clamping occurred; w must be < 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w, output logic ovf);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    ovf = (sum > lim);
    sat_add = ovf ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/knap_lane_sum.sv
// Masked LANES-wide adder tree feeding one saturating accumulator; adds one chunk per en cycle.
// Result visible the cycle after en; no flow control of its own, clr takes priority over en.
module knap_lane_sum
  import knap_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic [LANES-1:0][COEF_W-1:0] coef,
  input  logic [LANES-1:0]             mask,
  output logic [ACC_W-1:0]             acc,
  output logic                         ovf
);

  logic [31:0]      tree;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;

  always_comb begin
    tree    = '0;
    ovf_nxt = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) tree = tree + 32'(coef[l]);
    end
    acc_nxt = ACC_W'(sat_add(32'(acc), tree, ACC_W, ovf_nxt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= acc_nxt;
      ovf <= ovf | ovf_nxt;
    end
  end

endmodule

// File: rtl/knap_eval_seq.sv
// Knapsack candidate evaluator: runtime coefficient table, LANES items summed per cycle, best-so-far tracking.
// out_valid N_ITEMS/LANES+1 cycles after the accept cycle; result held until out_ready, in_ready low while busy.
module knap_eval_seq
  import knap_pkg::*;
#(
  parameter int N_ITEMS = 16,
  parameter int COEF_W  = 8,
  parameter int ACC_W   = 12,
  parameter int LANES   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(N_ITEMS)-1:0] cfg_idx,
  input  logic [COEF_W-1:0]          cfg_value,
  input  logic [COEF_W-1:0]          cfg_weight,
  input  logic [COEF_W-1:0]          cfg_volume,
  output logic                       cfg_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_ITEMS-1:0]         in_sel,
  input  logic [COEF_W-1:0]          in_min_value,
  input  logic [COEF_W-1:0]          in_max_weight,
  input  logic [COEF_W-1:0]          in_max_volume,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_feasible,
  output logic [ACC_W-1:0]           out_value,
  output logic [ACC_W-1:0]           out_weight,
  output logic [ACC_W-1:0]           out_volume,
  output logic [2:0]                 out_ovf,
  input  logic                       best_clr,
  output logic                       best_valid,
  output logic [ACC_W-1:0]           best_value,
  output logic [N_ITEMS-1:0]         best_sel
);

  localparam int NCH   = N_ITEMS / LANES;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IDX_W = $clog2(N_ITEMS);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_DONE  = DONE;

  if (N_ITEMS % LANES != 0) begin : g_bad_lanes
    $error("N_ITEMS must be a multiple of LANES");
  end
  if (ACC_W < COEF_W || ACC_W > 31) begin : g_bad_acc
    $error("ACC_W must be in [COEF_W, 31]");
  end
  if (COEF_W != KNAP_COEF_W) begin : g_bad_coef
    $error("COEF_W must match the coefficient record width");
  end

  logic [1:0]        state_q;
  logic              rdy_en_q;
  logic [CH_W-1:0]   chunk_q;
  logic [N_ITEMS-1:0] sel_q;
  logic [COEF_W-1:0] min_q, maxw_q, maxv_q;
  coef_t             tbl [N_ITEMS];

  logic                         accept;
  logic [IDX_W-1:0]             item;
  logic [LANES-1:0]             lane_mask;
  logic [LANES-1:0][COEF_W-1:0] lane_val, lane_wt, lane_vol;
  logic                         ovf_val, ovf_wt, ovf_vol;

  assign in_ready  = rdy_en_q && (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign out_ovf   = {ovf_vol, ovf_wt, ovf_val};

  // Value saturation alone does not fail the candidate; weight/volume saturation does.
  assign out_feasible = out_valid
                     && (out_value  >= ACC_W'(min_q))
                     && (out_weight <= ACC_W'(maxw_q))
                     && (out_volume <= ACC_W'(maxv_q))
                     && !ovf_wt && !ovf_vol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) tbl[i] <= '0;
    end else if (cfg_we && state_q == ST_IDLE && int'(cfg_idx) < N_ITEMS) begin
      tbl[cfg_idx] <= '{value: cfg_value, weight: cfg_weight, volume: cfg_volume};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
      chunk_q  <= '0;
      sel_q    <= '0;
      min_q    <= '0;
      maxw_q   <= '0;
      maxv_q   <= '0;
      cfg_err  <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      cfg_err  <= cfg_we && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: if (accept) begin
          sel_q   <= in_sel;
          min_q   <= in_min_value;
          maxw_q  <= in_max_weight;
          maxv_q  <= in_max_volume;
          chunk_q <= '0;
          state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          chunk_q <= chunk_q + CH_W'(1);
          if (chunk_q == CH_W'(NCH - 1)) state_q <= ST_DONE;
        end
        ST_DONE: if (out_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    item      = '0;
    lane_mask = '0;
    lane_val  = '0;
    lane_wt   = '0;
    lane_vol  = '0;
    for (int l = 0; l < LANES; l++) begin
      item         = IDX_W'(int'(chunk_q) * LANES + l);
      lane_mask[l] = sel_q[item];
      lane_val[l]  = tbl[item].value;
      lane_wt[l]   = tbl[item].weight;
      lane_vol[l]  = tbl[item].volume;
    end
  end

  knap_lane_sum #(.LANES(LANES), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_sum_val (
    .clk(clk), .rst_n(rst_n), .clr(accept), .en(state_q == ST_ACCUM),
    .coef(lane_val), .mask(lane_mask), .acc(out_value), .ovf(ovf_val)
  );

  knap_lane_sum #(.LANES(LANES), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_sum_wt (
    .clk(clk), .rst_n(rst_n), .clr(accept), .en(state_q == ST_ACCUM),
    .coef(lane_wt), .mask(lane_mask), .acc(out_weight), .ovf(ovf_wt)
  );

  knap_lane_sum #(.LANES(LANES), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_sum_vol (
    .clk(clk), .rst_n(rst_n), .clr(accept), .en(state_q == ST_ACCUM),
    .coef(lane_vol), .mask(lane_mask), .acc(out_volume), .ovf(ovf_vol)
  );

  // Ties keep the earlier candidate; a clear beats a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_valid <= 1'b0;
      best_value <= '0;
      best_sel   <= '0;
    end else if (best_clr) begin
      best_valid <= 1'b0;
      best_value <= '0;
      best_sel   <= '0;
    end else if (out_valid && out_ready && out_feasible &&
                 (!best_valid || out_value > best_value)) begin
      best_valid <= 1'b1;
      best_value <= out_value;
      best_sel   <= sel_q;
    end
  end

endmodule

// File: tb/tb_knap_eval_seq.sv
// Bench for knap_eval_seq: scoreboard of modelled results checked on each output handshake,
// plus per-scenario inline checks; a second instance with ACC_W=10 and all weights 255 covers saturation.
module tb_knap_eval_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [7:0]  cfg_value = '0, cfg_weight = '0, cfg_volume = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_sel = '0;
  logic [7:0]  in_min_value = '0, in_max_weight = '0, in_max_volume = '0;
  logic        out_ready = 1'b1;
  logic        best_clr = 1'b0;

  logic        cfg_err, in_ready, out_valid, out_feasible, best_valid;
  logic [11:0] out_value, out_weight, out_volume, best_value;
  logic [2:0]  out_ovf;
  logic [15:0] best_sel;

  logic        d10_cfg_err, d10_in_ready, d10_out_valid, d10_out_feasible, d10_best_valid;
  logic [9:0]  d10_out_value, d10_out_weight, d10_out_volume, d10_best_value;
  logic [2:0]  d10_out_ovf;
  logic [15:0] d10_best_sel;

  always #5 clk = ~clk;

  knap_eval_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_value(cfg_value), .cfg_weight(cfg_weight), .cfg_volume(cfg_volume), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_min_value(in_min_value),
    .in_max_weight(in_max_weight), .in_max_volume(in_max_volume),
    .out_valid(out_valid), .out_ready(out_ready), .out_feasible(out_feasible),
    .out_value(out_value), .out_weight(out_weight), .out_volume(out_volume), .out_ovf(out_ovf),
    .best_clr(best_clr), .best_valid(best_valid), .best_value(best_value), .best_sel(best_sel)
  );

  knap_eval_seq #(.ACC_W(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_value(cfg_value), .cfg_weight(8'hFF), .cfg_volume(cfg_volume), .cfg_err(d10_cfg_err),
    .in_valid(in_valid), .in_ready(d10_in_ready), .in_sel(in_sel), .in_min_value(in_min_value),
    .in_max_weight(in_max_weight), .in_max_volume(in_max_volume),
    .out_valid(d10_out_valid), .out_ready(out_ready), .out_feasible(d10_out_feasible),
    .out_value(d10_out_value), .out_weight(d10_out_weight), .out_volume(d10_out_volume),
    .out_ovf(d10_out_ovf), .best_clr(best_clr), .best_valid(d10_best_valid),
    .best_value(d10_best_value), .best_sel(d10_best_sel)
  );

  typedef struct {
    logic [15:0] sel;
    logic [11:0] v, w, vol;
    logic [2:0]  ovf;
    logic        feas;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0, n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic [7:0] iv[16], iw[16], ivol[16];
  logic [7:0] tv[16], tw[16], tvol[16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [15:0] s, input logic [7:0] mn, mw, mv);
    exp_t e;
    int sv = 0, sw = 0, so = 0;
    for (int i = 0; i < 16; i++) begin
      if (s[i]) begin
        sv += int'(tv[i]);
        sw += int'(tw[i]);
        so += int'(tvol[i]);
      end
    end
    e.sel  = s;
    e.ovf  = {so > 4095, sw > 4095, sv > 4095};
    e.v    = (sv > 4095) ? 12'hFFF : 12'(sv);
    e.w    = (sw > 4095) ? 12'hFFF : 12'(sw);
    e.vol  = (so > 4095) ? 12'hFFF : 12'(so);
    e.feas = (e.v >= 12'(mn)) && (e.w <= 12'(mw)) && (e.vol <= 12'(mv)) && !e.ovf[1] && !e.ovf[2];
    return e;
  endfunction

  // Output monitor: pops one expectation per output handshake.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb_empty: result value=%0d arrived with no expectation", out_value);
      end else begin
        mon_e = sbq.pop_front();
        n_vec += 5;
        if (out_value !== mon_e.v) begin n_bad++; $display("FAIL value sel=%h: got %0d want %0d", mon_e.sel, out_value, mon_e.v); end
        if (out_weight !== mon_e.w) begin n_bad++; $display("FAIL weight sel=%h: got %0d want %0d", mon_e.sel, out_weight, mon_e.w); end
        if (out_volume !== mon_e.vol) begin n_bad++; $display("FAIL volume sel=%h: got %0d want %0d", mon_e.sel, out_volume, mon_e.vol); end
        if (out_ovf !== mon_e.ovf) begin n_bad++; $display("FAIL ovf sel=%h: got %b want %b", mon_e.sel, out_ovf, mon_e.ovf); end
        if (out_feasible !== mon_e.feas) begin n_bad++; $display("FAIL feasible sel=%h: got %b want %b", mon_e.sel, out_feasible, mon_e.feas); end
      end
    end
  end

  task automatic cfg_write(input int i, input logic [7:0] v, w, o);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 4'(i); cfg_value = v; cfg_weight = w; cfg_volume = o;
    @(negedge clk);
    cfg_we = 1'b0;
    tv[i] = v; tw[i] = w; tvol[i] = o;
  endtask

  task automatic send(input logic [15:0] s, input logic [7:0] mn, mw, mv);
    int g = 0;
    sbq.push_back(model(s, mn, mw, mv));
    @(negedge clk);
    in_valid = 1'b1; in_sel = s; in_min_value = mn; in_max_weight = mw; in_max_volume = mv;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!out_valid && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!out_valid) begin
      n_vec++; n_bad++;
      $display("FAIL out_valid_timeout: out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec += 2;
    if ({in_ready, out_valid, cfg_err, best_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctl: {in_ready,out_valid,cfg_err,best_valid}=%b want 0000", {in_ready, out_valid, cfg_err, best_valid});
    end
    if ({out_value, out_weight, out_volume, out_ovf, out_feasible, best_value, best_sel} !== '0) begin
      n_bad++; $display("FAIL reset_data: value=%0d weight=%0d volume=%0d best=%0d want all 0", out_value, out_weight, out_volume, best_value);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_edge: got %b want 1", in_ready); end
  endtask

  task automatic load_table();
    for (int i = 0; i < 16; i++) cfg_write(i, iv[i], iw[i], ivol[i]);
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    send(16'h0000, 8'd120, 8'd60, 8'd60);
    wait_valid();
    @(posedge clk);
    #1;
    n_vec++;
    if (best_valid !== 1'b0) begin n_bad++; $display("FAIL zero_best_valid: got %b want 0", best_valid); end
  endtask

  task automatic test_basic();
    int lat;
    send(16'h1EC8, 8'd120, 8'd60, 8'd60);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_vec++;
    if (lat !== 5) begin n_bad++; $display("FAIL latency: got %0d cycles want 5", lat); end
    @(posedge clk);
    #1;
    n_vec++;
    if ({best_valid, best_value, best_sel} !== {1'b1, 12'd121, 16'h1EC8}) begin
      n_bad++; $display("FAIL best_after_basic: valid=%b value=%0d sel=%h want 1/121/1ec8", best_valid, best_value, best_sel);
    end
  endtask

  task automatic test_full();
    send(16'hFFFF, 8'd120, 8'd60, 8'd60);
    wait_valid();
    n_vec++;
    if ({d10_out_valid, d10_out_weight, d10_out_ovf, d10_out_feasible} !== {1'b1, 10'd1023, 3'b010, 1'b0}) begin
      n_bad++; $display("FAIL sat10: valid=%b weight=%0d ovf=%b feasible=%b want 1/1023/010/0",
                        d10_out_valid, d10_out_weight, d10_out_ovf, d10_out_feasible);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold();
    logic [36:0] snap;
    out_ready = 1'b0;
    send(16'h0008, 8'd0, 8'd255, 8'd255);
    wait_valid();
    snap = {out_value, out_weight, out_volume, out_feasible};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cfg_we = (k == 3); cfg_idx = 4'd3; cfg_value = 8'd99; cfg_weight = 8'd99; cfg_volume = 8'd99;
      #1;
      n_vec++;
      if ({out_valid, in_ready, out_value, out_weight, out_volume, out_feasible} !== {2'b10, snap}) begin
        n_bad++; $display("FAIL hold_k%0d: valid=%b ready=%b value=%0d want held 1/0/%0d", k, out_valid, in_ready, out_value, snap[36:25]);
      end
      if (k == 4) begin
        n_vec++;
        if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err_pulse: got %b want 1", cfg_err); end
      end
      if (k == 6) begin
        n_vec++;
        if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err); end
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    send(16'h0008, 8'd0, 8'd255, 8'd255);
    wait_valid();
    @(posedge clk);
    #1;
  endtask

  task automatic test_best();
    @(negedge clk);
    best_clr = 1'b1;
    @(negedge clk);
    best_clr = 1'b0;
    n_vec++;
    if (best_valid !== 1'b0) begin n_bad++; $display("FAIL best_clr_idle: got %b want 0", best_valid); end
    send(16'h1EC8, 8'd120, 8'd60, 8'd60);
    wait_valid();
    @(posedge clk);
    send(16'h1ECC, 8'd120, 8'd100, 8'd100);
    wait_valid();
    @(posedge clk);
    #1;
    n_vec++;
    if ({best_valid, best_value, best_sel} !== {1'b1, 12'd121, 16'h1EC8}) begin
      n_bad++; $display("FAIL best_tie: valid=%b value=%0d sel=%h want 1/121/1ec8", best_valid, best_value, best_sel);
    end
    out_ready = 1'b0;
    send(16'hFFFF, 8'd0, 8'd255, 8'd255);
    wait_valid();
    @(negedge clk);
    out_ready = 1'b1; best_clr = 1'b1;
    @(negedge clk);
    best_clr = 1'b0;
    n_vec++;
    if ({best_valid, best_value, best_sel} !== '0) begin
      n_bad++; $display("FAIL best_clr_wins: valid=%b value=%0d sel=%h want 0/0/0", best_valid, best_value, best_sel);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2, c3;
    out_ready = 1'b1;
    send(16'h0F0F, 8'd10, 8'd200, 8'd200); c1 = acc_cyc;
    send(16'hF0F0, 8'd10, 8'd200, 8'd200); c2 = acc_cyc;
    send(16'h5555, 8'd10, 8'd200, 8'd200); c3 = acc_cyc;
    n_vec += 2;
    if (c2 - c1 !== 6) begin n_bad++; $display("FAIL period_1: got %0d want 6", c2 - c1); end
    if (c3 - c2 !== 6) begin n_bad++; $display("FAIL period_2: got %0d want 6", c3 - c2); end
    wait_valid();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    send(16'hFFFF, 8'd0, 8'd255, 8'd255);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    for (int i = 0; i < 16; i++) begin tv[i] = '0; tw[i] = '0; tvol[i] = '0; end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_output: out_valid seen=%b want 0", seen); end
    send(16'hFFFF, 8'd0, 8'd0, 8'd0);
    wait_valid();
    @(posedge clk);
    #1;
  endtask

  initial begin
    iv   = '{4, 8, 0, 20, 10, 12, 18, 14, 6, 15, 30, 8, 16, 18, 18, 14};
    iw   = '{28, 8, 27, 18, 27, 28, 6, 1, 20, 0, 5, 13, 8, 14, 22, 12};
    ivol = '{27, 27, 4, 4, 0, 24, 4, 20, 12, 15, 5, 2, 9, 28, 19, 18};
    for (int i = 0; i < 16; i++) begin tv[i] = '0; tw[i] = '0; tvol[i] = '0; end
    test_reset();
    load_table();
    test_zero();
    test_basic();
    test_full();
    test_hold();
    test_best();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_vec++;
    if (sbq.size() !== 0) begin n_bad++; $display("FAIL sb_leftover: %0d results outstanding want 0", sbq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
